// File: rtl/operand_bypass_stage_pkg.sv
// ============================================================================
// Module      : operand_bypass_stage_pkg
// Description : Shared types and constants for the operand bypass stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package operand_bypass_stage_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_AW     = 4;
    localparam int DEF_NUM_RD     = 2;
    localparam int DEF_HIST_DEPTH = 3;
    localparam int DEF_IMM_W      = 8;

    // Register 0 reads as zero and is never forwarded.
    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic                  valid;
        logic                  pending;
        logic [DEF_REG_AW-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } hist_slot_t;

endpackage : operand_bypass_stage_pkg

`default_nettype wire

// File: rtl/operand_bypass_stage_bypass_port_select.sv
// ============================================================================
// Module      : bypass_port_select
// Description : Youngest-match forwarding selector for one operand read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bypass_port_select
    import operand_bypass_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int HIST_DEPTH = DEF_HIST_DEPTH
) (
    input  logic [REG_AW-1:0]            i_rd_addr,
    input  logic [DATA_W-1:0]            i_rf_data,
    input  logic [HIST_DEPTH-1:0]        i_slot_valid,
    input  logic                         i_slot0_pending,
    input  logic [HIST_DEPTH*REG_AW-1:0] i_slot_addr,
    input  logic [HIST_DEPTH*DATA_W-1:0] i_slot_data,
    output logic [DATA_W-1:0]            o_sel_data,
    output logic                         o_fwd_hit,
    output logic                         o_pend_hit
);

    logic w_addr_live;
    assign w_addr_live = (i_rd_addr != REG_AW'(REG_ZERO));

    // Scan oldest to youngest so the youngest match is the last to overwrite.
    always_comb begin
        o_sel_data = i_rf_data;
        o_fwd_hit  = 1'b0;
        for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
            if (w_addr_live && i_slot_valid[k] &&
                (i_slot_addr[k*REG_AW +: REG_AW] == i_rd_addr)) begin
                o_sel_data = i_slot_data[k*DATA_W +: DATA_W];
                o_fwd_hit  = 1'b1;
            end
        end
    end

    assign o_pend_hit = w_addr_live && i_slot_valid[0] && i_slot0_pending &&
                        (i_slot_addr[0 +: REG_AW] == i_rd_addr);

endmodule : bypass_port_select

`default_nettype wire

// File: rtl/operand_bypass_stage.sv
// ============================================================================
// Module      : operand_bypass_stage
// Description : Operand fetch/forwarding stage with load-use hazard detection
//               and registered operands. Optional FWD_STATS_EN adds counters.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module operand_bypass_stage
    import operand_bypass_stage_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_AW     = DEF_REG_AW,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int HIST_DEPTH = DEF_HIST_DEPTH,
    parameter int IMM_W      = DEF_IMM_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [NUM_RD*REG_AW-1:0] rd_addr,
    input  logic [NUM_RD*DATA_W-1:0] rf_data,
    input  logic [IMM_W-1:0]         imm,
    input  logic                     imm_sel,
    input  logic                     res_valid,
    input  logic [REG_AW-1:0]        res_addr,
    input  logic [DATA_W-1:0]        res_data,
    input  logic                     res_pending,
    input  logic [DATA_W-1:0]        ld_data,
    output logic [NUM_RD*DATA_W-1:0] op_data,
    output logic                     op_valid,
    output logic                     hazard
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]              fwd_hits,
    output logic [31:0]              hazard_cycles
`endif
);

    logic [HIST_DEPTH-1:0]        r_hist_valid;
    logic                         r_slot0_pending;
    logic [HIST_DEPTH*REG_AW-1:0] r_hist_addr;
    logic [HIST_DEPTH*DATA_W-1:0] r_hist_data;

    logic [DATA_W-1:0]            w_slot1_data;
    logic [NUM_RD*DATA_W-1:0]     w_sel_data;
    logic [NUM_RD-1:0]            w_fwd;
    logic [NUM_RD-1:0]            w_pend;

    // A pending load resolves as it moves into slot 1, so only slot 0 can be pending.
    assign w_slot1_data = r_slot0_pending ? ld_data : r_hist_data[0 +: DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist_valid    <= '0;
            r_slot0_pending <= 1'b0;
            r_hist_addr     <= '0;
            r_hist_data     <= '0;
        end else begin
            r_hist_valid    <= {r_hist_valid[HIST_DEPTH-2:0], res_valid};
            r_slot0_pending <= res_pending;
            r_hist_addr     <= {r_hist_addr[(HIST_DEPTH-1)*REG_AW-1:0], res_addr};
            r_hist_data     <= {r_hist_data[(HIST_DEPTH-1)*DATA_W-1:0], res_data};
            r_hist_data[DATA_W +: DATA_W] <= w_slot1_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_port
        logic [DATA_W-1:0] w_raw_data;
        logic              w_raw_fwd;
        logic              w_raw_pend;

        bypass_port_select #(
            .DATA_W     (DATA_W),
            .REG_AW     (REG_AW),
            .HIST_DEPTH (HIST_DEPTH)
        ) u_sel (
            .i_rd_addr       (rd_addr[i*REG_AW +: REG_AW]),
            .i_rf_data       (rf_data[i*DATA_W +: DATA_W]),
            .i_slot_valid    (r_hist_valid),
            .i_slot0_pending (r_slot0_pending),
            .i_slot_addr     (r_hist_addr),
            .i_slot_data     (r_hist_data),
            .o_sel_data      (w_raw_data),
            .o_fwd_hit       (w_raw_fwd),
            .o_pend_hit      (w_raw_pend)
        );

        if (i == 0) begin : g_imm
            assign w_sel_data[0 +: DATA_W] = imm_sel ? DATA_W'(imm) : w_raw_data;
            assign w_fwd[0]                = w_raw_fwd  && !imm_sel;
            assign w_pend[0]               = w_raw_pend && !imm_sel;
        end else begin : g_reg
            assign w_sel_data[i*DATA_W +: DATA_W] = w_raw_data;
            assign w_fwd[i]                       = w_raw_fwd;
            assign w_pend[i]                      = w_raw_pend;
        end
    end

    assign hazard = in_valid && (|w_pend);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_data  <= '0;
            op_valid <= 1'b0;
        end else if (flush) begin
            op_valid <= 1'b0;
        end else if (!stall) begin
            if (hazard) begin
                op_valid <= 1'b0;
            end else begin
                op_data  <= w_sel_data;
                op_valid <= in_valid;
            end
        end
    end

`ifdef FWD_STATS_EN
    logic w_accept;
    assign w_accept = !flush && !stall && !hazard && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_hits      <= '0;
            hazard_cycles <= '0;
        end else begin
            if (w_accept && (|w_fwd) && (fwd_hits != '1)) begin
                fwd_hits <= fwd_hits + 32'd1;
            end
            if (hazard && !stall && (hazard_cycles != '1)) begin
                hazard_cycles <= hazard_cycles + 32'd1;
            end
        end
    end
`else
    logic w_unused_fwd;
    assign w_unused_fwd = ^w_fwd;
`endif

endmodule : operand_bypass_stage

`default_nettype wire

// File: tb/tb_operand_bypass_stage.sv
// ============================================================================
// Module      : tb_operand_bypass_stage
// Description : Scoreboarded random + directed bench for operand_bypass_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_operand_bypass_stage;

    localparam int DATA_W     = 16;
    localparam int REG_AW     = 4;
    localparam int NUM_RD     = 2;
    localparam int HIST_DEPTH = 3;
    localparam int IMM_W      = 8;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid, stall, flush, imm_sel;
    logic [NUM_RD*REG_AW-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rf_data;
    logic [IMM_W-1:0]         imm;
    logic                     res_valid, res_pending;
    logic [REG_AW-1:0]        res_addr;
    logic [DATA_W-1:0]        res_data, ld_data;
    logic [NUM_RD*DATA_W-1:0] op_data;
    logic                     op_valid, hazard;
`ifdef FWD_STATS_EN
    logic [31:0]              fwd_hits, hazard_cycles;
`endif

    operand_bypass_stage #(
        .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_RD(NUM_RD),
        .HIST_DEPTH(HIST_DEPTH), .IMM_W(IMM_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
        .rd_addr(rd_addr), .rf_data(rf_data), .imm(imm), .imm_sel(imm_sel),
        .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
        .res_pending(res_pending), .ld_data(ld_data),
        .op_data(op_data), .op_valid(op_valid), .hazard(hazard)
`ifdef FWD_STATS_EN
        , .fwd_hits(fwd_hits), .hazard_cycles(hazard_cycles)
`endif
    );

    initial forever #5 clk = ~clk;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: history is a queue, front = most recent write.
    typedef struct {
        bit          v;
        bit          p;
        int unsigned addr;
        logic [15:0] data;
    } ent_t;
    typedef struct {
        bit          v;
        logic [31:0] d;
    } exp_t;

    ent_t        hist_q[$];
    exp_t        sb_q[$];
    bit          m_op_valid;
    logic [31:0] m_op_data;
    logic [31:0] m_sel;
    bit          m_any_fwd, m_hazard;
    int unsigned m_fwd_hits, m_hz_cycles;

    function automatic void model_reset();
        ent_t e;
        e = '{v: 0, p: 0, addr: 0, data: 16'h0};
        hist_q.delete();
        for (int k = 0; k < HIST_DEPTH; k++) hist_q.push_back(e);
        m_op_valid  = 0;
        m_op_data   = '0;
        m_fwd_hits  = 0;
        m_hz_cycles = 0;
    endfunction

    function automatic void model_comb();
        bit pend;
        pend      = 0;
        m_any_fwd = 0;
        for (int i = 0; i < NUM_RD; i++) begin
            int unsigned a;
            logic [15:0] v;
            a = rd_addr[i*REG_AW +: REG_AW];
            v = rf_data[i*DATA_W +: DATA_W];
            if (i == 0 && imm_sel) begin
                v = {8'h00, imm};
            end else if (a != 0) begin
                for (int k = 0; k < hist_q.size(); k++) begin
                    if (hist_q[k].v && hist_q[k].addr == a) begin
                        v = hist_q[k].data;
                        m_any_fwd = 1;
                        if (k == 0 && hist_q[k].p) pend = 1;
                        break;
                    end
                end
            end
            m_sel[i*16 +: 16] = v;
        end
        m_hazard = in_valid && pend;
    endfunction

    function automatic void model_clock();
        ent_t e;
        if (flush) m_op_valid = 0;
        else if (!stall) begin
            if (m_hazard) m_op_valid = 0;
            else begin
                m_op_data  = m_sel;
                m_op_valid = in_valid;
                if (in_valid && m_any_fwd) m_fwd_hits++;
            end
        end
        if (m_hazard && !stall) m_hz_cycles++;
        e = hist_q[0];
        if (e.p) begin
            e.data = ld_data;
            e.p    = 0;
        end
        hist_q[0] = e;
        e = '{v: res_valid, p: res_pending, addr: res_addr, data: res_data};
        hist_q.push_front(e);
        void'(hist_q.pop_back());
    endfunction

    // Inputs are already applied; evaluate, clock once, queue the expected output.
    task automatic step();
        exp_t x;
        #1;
        model_comb();
        check("hazard", hazard, m_hazard);
        @(posedge clk);
        model_clock();
        x.v = m_op_valid;
        x.d = m_op_data;
        sb_q.push_back(x);
        #1;
`ifdef FWD_STATS_EN
        check("fwd_hits", fwd_hits, m_fwd_hits);
        check("hazard_cycles", hazard_cycles, m_hz_cycles);
`endif
    endtask

    initial begin : monitor
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("op_valid", op_valid, e.v);
                check("op_data", op_data, e.d);
            end
        end
    end

    task automatic set_idle();
        in_valid = 0; stall = 0; flush = 0; imm_sel = 0; imm = '0;
        rd_addr = '0; rf_data = '0;
        res_valid = 0; res_pending = 0; res_addr = '0; res_data = '0; ld_data = '0;
    endtask

    task automatic write_res(input logic [3:0] a, input logic [15:0] d, input logic p);
        res_valid = 1; res_addr = a; res_data = d; res_pending = p;
    endtask

    initial begin : stim
        rst_n = 0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        check("reset op_valid", op_valid, 0);
        check("reset op_data", op_data, 0);
        check("reset hazard", hazard, 0);
        @(negedge clk);
        rst_n = 1;
        model_reset();
        step();

        // No forwarding with empty history
        in_valid = 1; rd_addr = {4'd2, 4'd1}; rf_data = {16'h0022, 16'h0011};
        step();
        check("nofwd data", op_data, 32'h0022_0011);
        check("nofwd valid", op_valid, 1);

        // Youngest of two writes to R3 wins
        set_idle(); write_res(4'd3, 16'h1111, 0); step();
        write_res(4'd3, 16'h2222, 0); step();
        set_idle(); in_valid = 1; rd_addr = {4'd3, 4'd3}; rf_data = {16'h5555, 16'h5555};
        step();
        check("youngest", op_data, 32'h2222_2222);

        // Load-use: bubble, then ld_data forwarded from slot 1
        set_idle(); write_res(4'd4, 16'hDEAD, 1); step();
        set_idle(); in_valid = 1; rd_addr = {4'd5, 4'd4}; rf_data = {16'h0505, 16'h0404};
        ld_data = 16'hBEEF;
        #1 check("loaduse hazard", hazard, 1);
        step();
        check("loaduse bubble", op_valid, 0);
        check("loaduse resolved", hazard, 0);
        step();
        check("loaduse data", op_data, 32'h0505_BEEF);
        check("loaduse valid", op_valid, 1);

        // R0 never forwards; immediate overrides a pending match
        set_idle(); write_res(4'd0, 16'hFFFF, 0); step();
        set_idle(); in_valid = 1; rd_addr = {4'd0, 4'd0}; step();
        check("r0 data", op_data, 0);
        set_idle(); write_res(4'd6, 16'h1234, 1); step();
        set_idle(); in_valid = 1; imm_sel = 1; imm = 8'hA5;
        rd_addr = {4'd7, 4'd6}; rf_data = {16'h0707, 16'h0606};
        #1 check("imm no hazard", hazard, 0);
        step();
        check("imm data", op_data, 32'h0707_00A5);

        // Stall holds outputs while history keeps moving
        set_idle(); in_valid = 1; rd_addr = {4'd9, 4'd8}; rf_data = {16'h0909, 16'h0808};
        step();
        stall = 1; rf_data = {16'hAAAA, 16'hBBBB};
        for (int c = 0; c < 3; c++) begin
            write_res(4'd8, 16'h7000 + 16'(c), 0);
            step();
            check("stall data", op_data, 32'h0909_0808);
            check("stall valid", op_valid, 1);
        end
        flush = 1; step();
        check("flush+stall", op_valid, 0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            stall       = ($urandom_range(0, 6) == 0);
            flush       = ($urandom_range(0, 12) == 0);
            imm_sel     = ($urandom_range(0, 3) == 0);
            imm         = 8'($urandom);
            rd_addr     = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            rf_data     = $urandom;
            res_valid   = ($urandom_range(0, 2) != 0);
            res_addr    = 4'($urandom_range(0, 7));
            res_data    = 16'($urandom);
            res_pending = ($urandom_range(0, 3) == 0);
            ld_data     = 16'($urandom);
            step();
        end

        // Asynchronous reset while a hazard is raised
        set_idle(); in_valid = 1; rd_addr = {4'd1, 4'd2}; write_res(4'd5, 16'h0, 1);
        step();
        set_idle(); in_valid = 1; rd_addr = {4'd5, 4'd0};
        #1;
        check("pre-reset hazard", hazard, 1);
        check("pre-reset valid", op_valid, 1);
        rst_n = 0;
        sb_q.delete();
        #1;
        check("async rst op_valid", op_valid, 0);
        check("async rst hazard", hazard, 0);
        check("async rst op_data", op_data, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        set_idle();
        model_reset();
        step();
        step();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule : tb_operand_bypass_stage

`default_nettype wire
